low_priority_arbiter_8: RTL

LOW_PRIORITY_ARBITER_8 -- requirements
Module: low_priority_arbiter_8

---
 rtl/low_priority_arbiter_pkg.sv | 12 +
 rtl/low_priority_pick_8.sv | 19 +
 rtl/low_priority_arbiter_8.sv | 131 +++++++++++++
 3 files changed

// File: rtl/low_priority_arbiter_pkg.sv
// rtl/low_priority_arbiter_pkg.sv - shared sizes and FSM state type for the 8-way arbiter
package low_priority_arbiter_pkg;
    localparam int NUM_REQ    = 8;
    localparam int IDX_W      = 3;
    localparam int HOLD_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;
endpackage

// File: rtl/low_priority_pick_8.sv
// rtl/low_priority_pick_8.sv - combinational lowest-set-bit picker over an 8-bit vector
module low_priority_pick_8
    import low_priority_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] vec_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/low_priority_arbiter_8.sv
// rtl/low_priority_arbiter_8.sv - 8-way hold-limited arbiter; LOW_PRIORITY_ARBITER_ROUND_ROBIN_EN selects round-robin
module low_priority_arbiter_8
    import low_priority_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD_CYCLES = 16
) (
    input  logic               Clock_In,
    input  logic               Reset_N_In,
    input  logic [NUM_REQ-1:0] Request_In,
    output logic [NUM_REQ-1:0] Grant_Out,
    output logic [IDX_W-1:0]   Grant_Index_Out,
    output logic               Grant_Valid_Out,
    output logic               Timeout_Out
);
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(MAX_HOLD_CYCLES - 1);

    arb_state_e            state_q, state_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0]    mask_q, mask_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    pick_vec;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W-1:0]      sel_idx;
    logic                  pick_valid;
    logic                  timeout;

    assign eligible = Request_In & ~mask_q;

`ifdef LOW_PRIORITY_ARBITER_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Rotate so the pointer position lands on bit 0, then undo the rotation on the index.
    always_comb begin
        pick_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_vec[i] = eligible[IDX_W'(i) + ptr_q];
        end
    end

    assign sel_idx = pick_idx + ptr_q;
    assign ptr_d   = (state_q == GRANT && state_d == RELEASE) ? idx_q + IDX_W'(1) : ptr_q;

    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign pick_vec = eligible;
    assign sel_idx  = pick_idx;
`endif

    low_priority_pick_8 u_pick (
        .vec_i   (pick_vec),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // A dropped request wins over expiry, so no timeout when the owner's bit is low.
    assign timeout = (state_q == GRANT) && Request_In[idx_q] && (hold_cnt_q == HOLD_LAST);
    assign mask_d  = (mask_q & Request_In) | (timeout ? grant_q : '0);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        case (state_q)
            // The release cycle doubles as the arbitration cycle, keeping the gap to one dead cycle.
            IDLE, RELEASE: begin
                if (pick_valid) begin
                    state_d    = GRANT;
                    hold_cnt_d = '0;
                    grant_d    = NUM_REQ'(1) << sel_idx;
                    idx_d      = sel_idx;
                    valid_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (!Request_In[idx_q] || timeout) begin
                    state_d = RELEASE;
                    grant_d = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                idx_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            mask_q     <= '0;
            grant_q    <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            mask_q     <= mask_d;
            grant_q    <= grant_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
        end
    end

    assign Grant_Out       = grant_q;
    assign Grant_Index_Out = idx_q;
    assign Grant_Valid_Out = valid_q;
    assign Timeout_Out     = timeout;
endmodule
